// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with write-through bypass and pending-write scoreboard
//
// Purpose: commits writeback results into the architectural register file,
// serves two combinational decode read ports with same-cycle bypass, and
// tracks in-flight writes per register so decode stalls on unresolved sources.
// A taken redirect at writeback (wb_pc_src) discards all in-flight bookkeeping.
//
// Optional feature macro: SCOREBOARD_PERF_EN adds perf_stall_cnt, a 32-bit
// wrapping count of stalled cycles (cleared by rst only).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_rf_wb/wb_rd/wb_data    writeback write enable, destination, data
//   wb_pc_src                 taken redirect at writeback, flushes scoreboard
//   id_rs1/id_rs2             decode source indices
//   id_use_rs1/id_use_rs2     decode actually reads the source
//   id_rd/id_rf_wb            decode destination and its write enable
//   id_valid                  decode holds an instruction attempting issue
//   rs1_data/rs2_data         source operands (combinational)
//   id_stall                  hold decode this cycle (combinational)
//   perf_stall_cnt            stall cycle counter (SCOREBOARD_PERF_EN only)

module regfile_scoreboard #(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_rf_wb,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        wb_pc_src,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rf_wb,
  input  logic        id_valid,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        id_stall
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0]       regs [32];
  logic [PEND_W-1:0] pend [32];

  logic wb_ev;
  logic issue_ev;
  logic haz1;
  logic haz2;
  logic full;

  assign wb_ev    = wb_rf_wb && (wb_rd != 5'd0);
  // A younger instruction issuing in the redirect cycle is killed, so it never counts.
  assign issue_ev = id_valid && !id_stall && id_rf_wb && (id_rd != 5'd0) && !wb_pc_src;

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (id_rs1 != 5'd0)
      rs1_data = (wb_rf_wb && wb_rd == id_rs1) ? wb_data : regs[id_rs1];
    if (id_rs2 != 5'd0)
      rs2_data = (wb_rf_wb && wb_rd == id_rs2) ? wb_data : regs[id_rs2];
  end

  // A source with exactly one outstanding write that is landing this cycle is
  // satisfied by the bypass, so it does not stall.
  assign haz1 = id_use_rs1 && (id_rs1 != 5'd0) && (pend[id_rs1] != '0) &&
                !(pend[id_rs1] == PEND_ONE && wb_ev && wb_rd == id_rs1);
  assign haz2 = id_use_rs2 && (id_rs2 != 5'd0) && (pend[id_rs2] != '0) &&
                !(pend[id_rs2] == PEND_ONE && wb_ev && wb_rd == id_rs2);
  // Saturated counter: stall the issue rather than let the count wrap.
  assign full = id_rf_wb && (id_rd != 5'd0) && (pend[id_rd] == PEND_MAX);

  assign id_stall = id_valid && (haz1 || haz2 || full);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_ev) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || wb_pc_src) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        // Issue and writeback to the same register in one cycle cancel out.
        if (issue_ev && id_rd == 5'(i) && !(wb_ev && wb_rd == 5'(i)))
          pend[i] <= pend[i] + PEND_ONE;
        else if (wb_ev && wb_rd == 5'(i) && !(issue_ev && id_rd == 5'(i)) &&
                 pend[i] != '0)
          pend[i] <= pend[i] - PEND_ONE;
      end
    end
  end

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (id_stall)
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard

module tb_regfile_scoreboard;

  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_rf_wb;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_pc_src;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_rf_wb;
  logic        id_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        id_stall;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  regfile_scoreboard #(.PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst),
    .wb_rf_wb(wb_rf_wb), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc_src(wb_pc_src),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rf_wb(id_rf_wb), .id_valid(id_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .id_stall(id_stall)
`ifdef SCOREBOARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural values and outstanding-write counts.
  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic [31:0] m_perf;

  task automatic idle();
    rst = 1'b0; wb_rf_wb = 1'b0; wb_rd = '0; wb_data = '0; wb_pc_src = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_rf_wb = 1'b0; id_valid = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (wb_rf_wb && wb_rd == rs) return wb_data;
    return m_regs[rs];
  endfunction

  function automatic logic exp_haz(input logic [4:0] rs, input logic use_rs);
    if (!use_rs || rs == 0 || m_pend[rs] == 0) return 1'b0;
    // last outstanding write arriving now is covered by the bypass
    if (m_pend[rs] == 1 && wb_rf_wb && wb_rd == rs) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_stall();
    logic f;
    f = id_rf_wb && id_rd != 0 && m_pend[id_rd] == PMAX;
    return id_valid && (exp_haz(id_rs1, id_use_rs1) || exp_haz(id_rs2, id_use_rs2) || f);
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    logic st;
    st = exp_stall();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_perf = '0;
    end else begin
      if (st) m_perf = m_perf + 32'd1;
      if (wb_rf_wb && wb_rd != 0) m_regs[wb_rd] = wb_data;
      if (wb_pc_src) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
        if (id_valid && !st && id_rf_wb && id_rd != 0) m_pend[id_rd]++;
        if (wb_rf_wb && wb_rd != 0 && m_pend[wb_rd] > 0) m_pend[wb_rd]--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    // reset dominates a concurrent writeback
    rst = 1'b1; wb_rf_wb = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555_AAAA;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      id_rs1 = 5'(i); id_rs2 = 5'(31 - i);
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_valid = 1'b1;
      #1;
      total++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || id_stall !== 1'b0) begin
        bad++;
        $display("FAIL reset_read x%0d: rs1=%h rs2=%h stall=%b, required 0 0 0", i, rs1_data, rs2_data, id_stall);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    wb_rf_wb = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; id_rs1 = 5'd5;
    #1;
    total++;
    if (rs1_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL bypass_same_cycle: got %h required %h", rs1_data, 32'hDEAD_BEEF);
    end
    tick();
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd5;
    #1;
    total++;
    if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL array_next_cycle: got %h/%h required %h", rs1_data, rs2_data, 32'hDEAD_BEEF);
    end
    wb_rf_wb = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    total++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      bad++; $display("FAIL x0_bypass: got %h/%h required 0", rs1_data, rs2_data);
    end
    tick();
    idle(); id_rs1 = 5'd0;
    #1;
    total++;
    if (rs1_data !== 32'h0) begin
      bad++; $display("FAIL x0_write_ignored: got %h required 0", rs1_data);
    end
  endtask

  task automatic test_hazard();
    idle();
    id_valid = 1'b1; id_rf_wb = 1'b1; id_rd = 5'd7;
    #1;
    total++;
    if (id_stall !== 1'b0) begin bad++; $display("FAIL issue_x7: stall=%b required 0", id_stall); end
    tick();
    idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (id_stall !== 1'b1) begin bad++; $display("FAIL raw_stall cyc%0d: stall=%b required 1", c, id_stall); end
      tick();
    end
    wb_rf_wb = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE_0007;
    #1;
    total++;
    if (id_stall !== 1'b0 || rs1_data !== 32'hCAFE_0007) begin
      bad++; $display("FAIL raw_release: stall=%b data=%h required 0 %h", id_stall, rs1_data, 32'hCAFE_0007);
    end
    tick();
    wb_rf_wb = 1'b0;
    #1;
    total++;
    if (id_stall !== 1'b0 || rs1_data !== 32'hCAFE_0007) begin
      bad++; $display("FAIL raw_after: stall=%b data=%h required 0 %h", id_stall, rs1_data, 32'hCAFE_0007);
    end
    tick();
    idle();
  endtask

  task automatic test_full();
    idle();
    id_valid = 1'b1; id_rf_wb = 1'b1; id_rd = 5'd3;
    for (int c = 0; c < PMAX; c++) begin
      #1;
      total++;
      if (id_stall !== 1'b0) begin bad++; $display("FAIL fill_x3 #%0d: stall=%b required 0", c, id_stall); end
      tick();
    end
    #1;
    total++;
    if (id_stall !== 1'b1) begin bad++; $display("FAIL full_stall: stall=%b required 1", id_stall); end
    tick();
    wb_rf_wb = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0333;
    #1;
    total++;
    if (id_stall !== 1'b1) begin bad++; $display("FAIL full_during_wb: stall=%b required 1", id_stall); end
    tick();
    wb_rf_wb = 1'b0;
    #1;
    total++;
    if (id_stall !== 1'b0) begin bad++; $display("FAIL full_release: stall=%b required 0", id_stall); end
    tick();
    // drain x3 back to zero
    idle();
    for (int c = 0; c < PMAX; c++) begin
      wb_rf_wb = 1'b1; wb_rd = 5'd3; wb_data = 32'(c);
      tick();
    end
    idle(); id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd3;
    #1;
    total++;
    if (id_stall !== 1'b0 || rs2_data !== 32'(PMAX - 1)) begin
      bad++; $display("FAIL drained_x3: stall=%b data=%h required 0 %h", id_stall, rs2_data, 32'(PMAX - 1));
    end
    idle();
  endtask

  task automatic test_flush();
    idle();
    id_valid = 1'b1; id_rf_wb = 1'b1; id_rd = 5'd9;  tick();
    id_rd = 5'd10; tick();
    id_rd = 5'd11; wb_pc_src = 1'b1; wb_rf_wb = 1'b1; wb_rd = 5'd1; wb_data = 32'h40;
    tick();
    idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_rs1 = 5'd9; id_rs2 = 5'd10;
    #1;
    total++;
    if (id_stall !== 1'b0) begin bad++; $display("FAIL flush_clears: stall=%b required 0", id_stall); end
    id_rs1 = 5'd1; id_rs2 = 5'd11;
    #1;
    total++;
    if (id_stall !== 1'b0 || rs1_data !== 32'h40) begin
      bad++; $display("FAIL flush_commit: stall=%b x1=%h required 0 %h", id_stall, rs1_data, 32'h40);
    end
    tick();
    idle();
  endtask

`ifdef SCOREBOARD_PERF_EN
  task automatic test_perf();
    idle(); rst = 1'b1; tick(); idle();
    total++;
    if (perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_reset: got %0d required 0", perf_stall_cnt); end
    id_valid = 1'b1; id_rf_wb = 1'b1; id_rd = 5'd12; tick();
    idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd12;
    for (int c = 0; c < 4; c++) tick();
    total++;
    if (perf_stall_cnt !== 32'd4) begin bad++; $display("FAIL perf_count: got %0d required 4", perf_stall_cnt); end
    idle(); wb_pc_src = 1'b1; tick(); idle(); tick();
    total++;
    if (perf_stall_cnt !== 32'd4) begin bad++; $display("FAIL perf_flush: got %0d required 4", perf_stall_cnt); end
    rst = 1'b1; tick(); idle();
    total++;
    if (perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_rst: got %0d required 0", perf_stall_cnt); end
  endtask
`endif

  task automatic test_random();
    idle();
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      wb_rf_wb   = $urandom_range(0, 1) == 1;
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      wb_pc_src  = ($urandom_range(0, 19) == 0);
      id_rs1     = 5'($urandom_range(0, 7));
      id_rs2     = 5'($urandom_range(0, 7));
      id_use_rs1 = $urandom_range(0, 1) == 1;
      id_use_rs2 = $urandom_range(0, 1) == 1;
      id_rd      = 5'($urandom_range(0, 7));
      id_rf_wb   = $urandom_range(0, 3) != 0;
      id_valid   = $urandom_range(0, 4) != 0;
      #1;
      total++;
      if (rs1_data !== exp_rd(id_rs1) || rs2_data !== exp_rd(id_rs2) || id_stall !== exp_stall()) begin
        bad++;
        $display("FAIL random cyc%0d: rs1=%h rs2=%h stall=%b required %h %h %b", c,
                 rs1_data, rs2_data, id_stall, exp_rd(id_rs1), exp_rd(id_rs2), exp_stall());
      end
`ifdef SCOREBOARD_PERF_EN
      total++;
      if (perf_stall_cnt !== m_perf) begin
        bad++; $display("FAIL random_perf cyc%0d: got %0d required %0d", c, perf_stall_cnt, m_perf);
      end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    m_perf = '0;
    idle();
    #1;
    test_reset();
    test_bypass();
    test_hazard();
    test_full();
    test_flush();
`ifdef SCOREBOARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
